// File: rtl/bram_arb_ctrl_if.sv
// Bus bundle for bram_arb_ctrl: Wishbone slave port, FIR/DMA engine port and RAM128 macro port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
`timescale 1ns/1ps

interface bram_arb_ctrl_if #(
    parameter int AW = 7
);
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;

    logic          eng_req_i;
    logic          eng_we_i;
    logic [3:0]    eng_be_i;
    logic [AW-1:0] eng_addr_i;
    logic [31:0]   eng_wdata_i;
    logic          eng_gnt_o;
    logic          eng_ack_o;
    logic [31:0]   eng_rdata_o;

    logic          ram_en_o;
    logic [3:0]    ram_we_o;
    logic [AW-1:0] ram_a_o;
    logic [31:0]   ram_di_o;
    logic [31:0]   ram_do_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  eng_req_i, eng_we_i, eng_be_i, eng_addr_i, eng_wdata_i,
        output eng_gnt_o, eng_ack_o, eng_rdata_o,
        output ram_en_o, ram_we_o, ram_a_o, ram_di_o,
        input  ram_do_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output eng_req_i, eng_we_i, eng_be_i, eng_addr_i, eng_wdata_i,
        input  eng_gnt_o, eng_ack_o, eng_rdata_o,
        input  ram_en_o, ram_we_o, ram_a_o, ram_di_o,
        output ram_do_i
    );
endinterface

// File: rtl/bram_arb_ctrl.sv
// Round-robin arbiter sharing one RAM128 between Wishbone and the FIR/DMA engine, one transaction in flight.
// Define ARB_FIXED_PRIO_EN for fixed priority (Wishbone always wins ties).
//
//  state | meaning
//  IDLE  | evaluate requests, latch the winner's command, drive RAM for the next cycle
//  ISSUE | RAM enabled with latched address/data/byte-enables; engine sees gnt
//  CAPT  | RAM output valid; reads load the owner's rdata register
//  WAIT  | DELAYS extra cycles emulating slow memory (skipped when DELAYS = 0)
//  RESP  | one-cycle ack to the owner; last-owner updated
`timescale 1ns/1ps

module bram_arb_ctrl #(
    parameter int COLS   = 1,
    parameter int DELAYS = 0
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    bram_arb_ctrl_if.slave bus
);
    localparam int AW = 7 + $clog2(COLS);
    localparam logic [3:0] DLY = 4'(DELAYS);
    localparam logic OWN_WB  = 1'b0;
    localparam logic OWN_ENG = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CAPT  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          last_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    cnt_q;
    logic          abort_q;

    logic          ram_en_q;
    logic [3:0]    ram_we_q;
    logic [AW-1:0] ram_a_q;
    logic [31:0]   ram_di_q;
    logic          eng_gnt_q;
    logic          eng_ack_q;
    logic          wb_ack_q;
    logic [31:0]   wb_rdata_q;
    logic [31:0]   eng_rdata_q;

    logic          wb_req;
    logic          eng_req;
    logic          pick_eng_d;
    logic          we_d;
    logic [3:0]    be_d;
    logic [AW-1:0] addr_d;
    logic [31:0]   wdata_d;
    logic          abort_d;
    logic          resp_d;

    logic unused_adr;
    assign unused_adr = ^{bus.wbs_adr_i[31:AW+2], bus.wbs_adr_i[1:0]};

    always_comb begin
        wb_req  = bus.wbs_cyc_i & bus.wbs_stb_i;
        eng_req = bus.eng_req_i;
`ifdef ARB_FIXED_PRIO_EN
        pick_eng_d = eng_req & ~wb_req;
`else
        // On a tie the port not served last wins; last_q resets to ENG so WB takes the first tie.
        pick_eng_d = eng_req & (~wb_req | (last_q == OWN_WB));
`endif
        if (pick_eng_d) begin
            we_d    = bus.eng_we_i;
            be_d    = bus.eng_be_i;
            addr_d  = bus.eng_addr_i;
            wdata_d = bus.eng_wdata_i;
        end else begin
            we_d    = bus.wbs_we_i;
            be_d    = bus.wbs_sel_i;
            addr_d  = bus.wbs_adr_i[AW+1:2];
            wdata_d = bus.wbs_dat_i;
        end
        // A WB master that drops cyc at any point in flight loses its ack for good.
        abort_d = abort_q | ((owner_q == OWN_WB) & ~bus.wbs_cyc_i);
        resp_d  = ((state_q == CAPT) && (DLY == 4'd0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1));
    end

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_q;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_WB;
            last_q      <= OWN_ENG;
            we_q        <= 1'b0;
            be_q        <= 4'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            abort_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'b0;
            ram_a_q     <= '0;
            ram_di_q    <= '0;
            eng_gnt_q   <= 1'b0;
            eng_ack_q   <= 1'b0;
            wb_ack_q    <= 1'b0;
            wb_rdata_q  <= '0;
            eng_rdata_q <= '0;
        end else begin
            ram_en_q  <= 1'b0;
            ram_we_q  <= 4'b0;
            ram_a_q   <= '0;
            ram_di_q  <= '0;
            eng_gnt_q <= 1'b0;
            eng_ack_q <= 1'b0;
            wb_ack_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (wb_req || eng_req) begin
                        owner_q   <= pick_eng_d;
                        we_q      <= we_d;
                        be_q      <= be_d;
                        addr_q    <= addr_d;
                        wdata_q   <= wdata_d;
                        abort_q   <= 1'b0;
                        ram_en_q  <= 1'b1;
                        ram_we_q  <= we_d ? be_d : 4'b0;
                        ram_a_q   <= addr_d;
                        ram_di_q  <= wdata_d;
                        eng_gnt_q <= pick_eng_d;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    abort_q <= abort_d;
                    state_q <= CAPT;
                end
                CAPT: begin
                    abort_q <= abort_d;
                    // RAM drives zero once EN drops, so this is the only cycle the read word exists.
                    if (!we_q) begin
                        if (owner_q == OWN_ENG) eng_rdata_q <= bus.ram_do_i;
                        else                    wb_rdata_q  <= bus.ram_do_i;
                    end
                    cnt_q   <= DLY;
                    state_q <= (DLY == 4'd0) ? RESP : WAIT;
                end
                WAIT: begin
                    abort_q <= abort_d;
                    cnt_q   <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
                RESP: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (resp_d) begin
                eng_ack_q <= (owner_q == OWN_ENG);
                wb_ack_q  <= (owner_q == OWN_WB) & ~abort_d;
            end
        end
    end

    assign bus.wbs_ack_o   = wb_ack_q & bus.wbs_cyc_i;
    assign bus.wbs_dat_o   = wb_rdata_q;
    assign bus.eng_gnt_o   = eng_gnt_q;
    assign bus.eng_ack_o   = eng_ack_q;
    assign bus.eng_rdata_o = eng_rdata_q;
    assign bus.ram_en_o    = ram_en_q;
    assign bus.ram_we_o    = ram_we_q;
    assign bus.ram_a_o     = ram_a_q;
    assign bus.ram_di_o    = ram_di_q;

    logic unused_cmd;
    assign unused_cmd = ^{be_q, addr_q, wdata_q};
endmodule

// File: tb/tb_bram_arb_ctrl.sv
// Self-checking bench for bram_arb_ctrl: vector table plus hand-written reset/abort/arbitration/wait-state sequences.
`timescale 1ns/1ps

module tb_bram_arb_ctrl;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    logic sb_en;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bram_arb_ctrl_if #(.AW(AW)) bus  ();
    bram_arb_ctrl_if #(.AW(AW)) bus3 ();

    bram_arb_ctrl #(.COLS(1), .DELAYS(0)) u_dut  (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus.slave));
    bram_arb_ctrl #(.COLS(1), .DELAYS(3)) u_dut3 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus3.slave));

    // RAM128 behavioural models: registered read, output forced to zero while EN is low.
    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
            bus.ram_do_i  <= '0;
            bus3.ram_do_i <= '0;
        end else begin
            if (bus.ram_en_o) begin
                bus.ram_do_i <= mem0[bus.ram_a_o];
                for (int b = 0; b < 4; b++)
                    if (bus.ram_we_o[b]) mem0[bus.ram_a_o][8*b +: 8] <= bus.ram_di_o[8*b +: 8];
            end else bus.ram_do_i <= '0;
            if (bus3.ram_en_o) begin
                bus3.ram_do_i <= mem1[bus3.ram_a_o];
                for (int b = 0; b < 4; b++)
                    if (bus3.ram_we_o[b]) mem1[bus3.ram_a_o][8*b +: 8] <= bus3.ram_di_o[8*b +: 8];
            end else bus3.ram_do_i <= '0;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic any_out_main();
        return |{bus.wbs_ack_o, bus.wbs_dat_o, bus.eng_gnt_o, bus.eng_ack_o, bus.eng_rdata_o,
                 bus.ram_en_o, bus.ram_we_o, bus.ram_a_o, bus.ram_di_o};
    endfunction

    function automatic logic any_out_d3();
        return |{bus3.wbs_ack_o, bus3.wbs_dat_o, bus3.eng_gnt_o, bus3.eng_ack_o, bus3.eng_rdata_o,
                 bus3.ram_en_o, bus3.ram_we_o, bus3.ram_a_o, bus3.ram_di_o};
    endfunction

    // Scoreboard: expected rdata-register contents, pushed at drive time, popped on each ack.
    logic [31:0] wb_q[$];
    logic [31:0] eng_q[$];
    logic [31:0] wb3_q[$];

    always @(negedge clk) begin
        if (sb_en && bus.wbs_ack_o) begin
            if (wb_q.size() == 0) check("wb_unexpected_ack", 32'd1, 32'd0);
            else check("wb_rdata", bus.wbs_dat_o, wb_q.pop_front());
        end
        if (sb_en && bus.eng_ack_o) begin
            if (eng_q.size() == 0) check("eng_unexpected_ack", 32'd1, 32'd0);
            else check("eng_rdata", bus.eng_rdata_o, eng_q.pop_front());
        end
        if (bus3.wbs_ack_o) begin
            if (wb3_q.size() == 0) check("wb3_unexpected_ack", 32'd1, 32'd0);
            else check("wb3_rdata", bus3.wbs_dat_o, wb3_q.pop_front());
        end
    end

    task automatic wb_txn(input logic we, input logic [3:0] sel, input logic [6:0] widx,
                          input logic [31:0] dat, input logic [31:0] exp_rd);
        int lat = 0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we; bus.wbs_sel_i = sel;
        bus.wbs_adr_i = 32'h3800_0000 | {23'd0, widx, 2'b00};
        bus.wbs_dat_i = dat;
        wb_q.push_back(exp_rd);
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.ram_en_o) begin
                check("wb_issue_cycle", 32'(c), 32'd1);
                check("wb_ram_we", {28'd0, bus.ram_we_o}, {28'd0, (we ? sel : 4'b0)});
                check("wb_ram_a", {25'd0, bus.ram_a_o}, {25'd0, widx});
                if (we) check("wb_ram_di", bus.ram_di_o, dat);
            end
            if (bus.wbs_ack_o) lat = c;
        end
        #2;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        check("wb_ack_latency", 32'(lat), 32'd3);
    endtask

    task automatic eng_txn(input logic we, input logic [3:0] be, input logic [6:0] addr,
                           input logic [31:0] dat, input logic [31:0] exp_rd);
        int gl = 0;
        int al = 0;
        @(negedge clk);
        bus.eng_req_i = 1'b1; bus.eng_we_i = we; bus.eng_be_i = be;
        bus.eng_addr_i = addr; bus.eng_wdata_i = dat;
        eng_q.push_back(exp_rd);
        for (int c = 1; c <= 12 && al == 0; c++) begin
            @(negedge clk);
            if (bus.ram_en_o) begin
                check("eng_ram_we", {28'd0, bus.ram_we_o}, {28'd0, (we ? be : 4'b0)});
                check("eng_ram_a", {25'd0, bus.ram_a_o}, {25'd0, addr});
                if (we) check("eng_ram_di", bus.ram_di_o, dat);
            end
            if (bus.eng_gnt_o) begin
                gl = c;
                #2 bus.eng_req_i = 1'b0;
            end
            if (bus.eng_ack_o) al = c;
        end
        check("eng_gnt_latency", 32'(gl), 32'd1);
        check("eng_ack_latency", 32'(al), 32'd3);
    endtask

    task automatic wb3_txn(input logic we, input logic [6:0] widx, input logic [31:0] dat,
                           input logic [31:0] exp_rd);
        int lat = 0;
        @(negedge clk);
        bus3.wbs_cyc_i = 1'b1; bus3.wbs_stb_i = 1'b1; bus3.wbs_we_i = we; bus3.wbs_sel_i = 4'hF;
        bus3.wbs_adr_i = {23'd0, widx, 2'b00};
        bus3.wbs_dat_i = dat;
        wb3_q.push_back(exp_rd);
        for (int c = 1; c <= 16 && lat == 0; c++) begin
            @(negedge clk);
            if (bus3.wbs_ack_o) lat = c;
        end
        #2;
        bus3.wbs_cyc_i = 1'b0; bus3.wbs_stb_i = 1'b0;
        check("wb3_ack_latency", 32'(lat), 32'd6);
        @(negedge clk);
        check("wb3_ack_width", {31'd0, bus3.wbs_ack_o}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        eng;
        logic        we;
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];
    logic owners[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acks;
        int n_own;

        vecs[0]  = '{1'b1, 1'b1, 4'hF, 7'd4,   32'h1122_3344, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 4'h3, 7'd4,   32'hAABB_CCDD, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b0, 4'hF, 7'd4,   32'h0,         32'h1122_CCDD};
        vecs[3]  = '{1'b1, 1'b1, 4'hF, 7'd5,   32'hDEAD_BEEF, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 4'hF, 7'd5,   32'h0,         32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b0, 4'hF, 7'd5,   32'h0,         32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 4'hC, 7'd127, 32'hA5A5_5A5A, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b1, 4'h1, 7'd127, 32'h1234_56FF, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b0, 4'hF, 7'd127, 32'h0,         32'hA5A5_00FF};
        vecs[9]  = '{1'b0, 1'b0, 4'hF, 7'd127, 32'h0,         32'hA5A5_00FF};
        vecs[10] = '{1'b1, 1'b0, 4'hF, 7'd4,   32'h0,         32'h1122_CCDD};
        vecs[11] = '{1'b0, 1'b1, 4'h0, 7'd0,   32'hFFFF_FFFF, 32'hA5A5_00FF};
        vecs[12] = '{1'b0, 1'b0, 4'hF, 7'd0,   32'h0,         32'h0000_0000};
        vecs[13] = '{1'b1, 1'b1, 4'h6, 7'd0,   32'hCAFE_F00D, 32'h1122_CCDD};
        vecs[14] = '{1'b0, 1'b0, 4'hF, 7'd0,   32'h0,         32'h00FE_F000};

        rst = 1'b1; mem_clr = 1'b1; sb_en = 1'b1;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
        bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.eng_req_i = 0; bus.eng_we_i = 0; bus.eng_be_i = 0; bus.eng_addr_i = 0; bus.eng_wdata_i = 0;
        bus3.wbs_cyc_i = 0; bus3.wbs_stb_i = 0; bus3.wbs_we_i = 0; bus3.wbs_sel_i = 0;
        bus3.wbs_adr_i = 0; bus3.wbs_dat_i = 0;
        bus3.eng_req_i = 0; bus3.eng_we_i = 0; bus3.eng_be_i = 0; bus3.eng_addr_i = 0; bus3.eng_wdata_i = 0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        rst = 1'b0;
        check("reset_outputs", {31'd0, any_out_main()}, 32'd0);
        check("reset_outputs_d3", {31'd0, any_out_d3()}, 32'd0);

        // Reset held two cycles while a WB read sits in ISSUE.
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = 32'h0000_0020;
        @(negedge clk);
        check("rst_test_issue_en", {31'd0, bus.ram_en_o}, 32'd1);
        #2;
        rst = 1'b1; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("rst_mid_read_c1", {31'd0, any_out_main()}, 32'd0);
        @(negedge clk);
        check("rst_mid_read_c2", {31'd0, any_out_main()}, 32'd0);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        wb_txn(1'b0, 4'hF, 7'd8, 32'h0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].eng) eng_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);
            else             wb_txn (vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);
        end

        // WB write abandoned during CAPT: no ack, but the RAM word is still written.
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = {23'd0, 7'd10, 2'b00}; bus.wbs_dat_i = 32'h5555_AAAA;
        @(negedge clk);
        @(negedge clk);
        #2;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        n_acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.wbs_ack_o) n_acks++;
        end
        check("abort_no_ack", 32'(n_acks), 32'd0);
        wb_txn(1'b0, 4'hF, 7'd10, 32'h0, 32'h5555_AAAA);

        // Both ports request continuously from a fresh reset.
        do_reset();
        sb_en = 1'b0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = {23'd0, 7'd4, 2'b00};
        bus.eng_req_i = 1'b1; bus.eng_we_i = 1'b0; bus.eng_addr_i = 7'd5;
        n_own = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.ram_en_o) begin
                if (n_own < 4) owners[n_own] = bus.eng_gnt_o;
                n_own++;
            end
        end
        #2;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.eng_req_i = 1'b0;
        check("arb_issue_count", 32'(n_own), 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            check("arb_owner", {31'd0, owners[k]}, 32'd0);
`else
            check("arb_owner", {31'd0, owners[k]}, {31'd0, logic'(k % 2)});
`endif
        end
        repeat (6) @(negedge clk);
        sb_en = 1'b1;

        // DELAYS = 3 instance: ack at T+6, one cycle wide.
        wb3_txn(1'b1, 7'd9, 32'h0BAD_F00D, 32'h0);
        wb3_txn(1'b0, 7'd9, 32'h0,         32'h0BAD_F00D);

        // Reset while the DELAYS = 3 instance sits in WAIT.
        @(negedge clk);
        bus3.wbs_cyc_i = 1'b1; bus3.wbs_stb_i = 1'b1; bus3.wbs_we_i = 1'b0; bus3.wbs_sel_i = 4'hF;
        bus3.wbs_adr_i = {23'd0, 7'd9, 2'b00};
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1; bus3.wbs_cyc_i = 1'b0; bus3.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("rst_in_wait_outputs", {31'd0, any_out_d3()}, 32'd0);
        #2 rst = 1'b0;
        n_acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus3.wbs_ack_o) n_acks++;
        end
        check("rst_in_wait_no_ack", 32'(n_acks), 32'd0);
        wb3_txn(1'b0, 7'd9, 32'h0, 32'h0BAD_F00D);

        repeat (4) @(negedge clk);
        check("wb_sb_drained",  32'(wb_q.size()),  32'd0);
        check("eng_sb_drained", 32'(eng_q.size()), 32'd0);
        check("wb3_sb_drained", 32'(wb3_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
